// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Round-robin arbiter between the data-memory ports of N_CORES cores and a
//   single shared RAM. One core is granted at a time. An atomic load pins the
//   grant to its core until that core's atomic store completes, or until the
//   lock has been idle for LOCK_TIMEOUT cycles (0 = no timeout).
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   en                  global enable; 0 freezes state, blocks the RAM, stalls cores
//   core_mem_read/write/atomic [N_CORES]   per-core strobes and atomic qualifier
//   core_mem_addr   [N_CORES*ADDR_W]       packed, core i at [i*ADDR_W +: ADDR_W]
//   core_mem_data_w [N_CORES*DATA_W]       packed write data
//   core_mem_data_r [DATA_W]               read data broadcast (= mem_data_r)
//   core_mem_wait   [N_CORES]              per-core stall
//   mem_read/write/atomic, mem_addr, mem_data_w    request towards the RAM
//   mem_data_r, mem_wait                           RAM response and stall
module mem_arbiter #(
  parameter int N_CORES      = 2,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [N_CORES-1:0]          core_mem_read,
  input  logic [N_CORES-1:0]          core_mem_write,
  input  logic [N_CORES-1:0]          core_mem_atomic,
  input  logic [N_CORES*ADDR_W-1:0]   core_mem_addr,
  input  logic [N_CORES*DATA_W-1:0]   core_mem_data_w,
  output logic [DATA_W-1:0]           core_mem_data_r,
  output logic [N_CORES-1:0]          core_mem_wait,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic                        mem_atomic,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_data_w,
  input  logic [DATA_W-1:0]           mem_data_r,
  input  logic                        mem_wait
);

  localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int CNT_W = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, GRANT, LOCK} state_t;

  state_t             state;
  logic [IDX_W-1:0]   grant;
  logic [IDX_W-1:0]   last;
  logic [CNT_W-1:0]   lock_cnt;

  logic [N_CORES-1:0] req;
  logic [IDX_W-1:0]   pick;
  logic               g_read, g_write, g_atomic;
  logic [ADDR_W-1:0]  g_addr;
  logic [DATA_W-1:0]  g_data;
  logic               forwarding;
  logic               active;
  logic               done;

  assign req = core_mem_read | core_mem_write;

  // Signals of the granted core.
  always_comb begin
    g_read   = 1'b0;
    g_write  = 1'b0;
    g_atomic = 1'b0;
    g_addr   = '0;
    g_data   = '0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      if (grant == IDX_W'(i)) begin
        g_read   = core_mem_read[i];
        g_write  = core_mem_write[i];
        g_atomic = core_mem_atomic[i];
        g_addr   = core_mem_addr[i*ADDR_W +: ADDR_W];
        g_data   = core_mem_data_w[i*DATA_W +: DATA_W];
      end
    end
  end

  // Round-robin pick: first requester after `last`, wrapping.
  always_comb begin
    logic found;
    found = 1'b0;
    pick  = last;
    for (int unsigned k = 1; k <= N_CORES; k++) begin
      int unsigned idx;
      idx = (32'(last) + k) % N_CORES;
      if (!found && req[idx]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
  end

  // GRANT and LOCK both forward the owner combinationally; reset blocks it.
  assign forwarding = (state != IDLE) && !rst;
  assign active     = forwarding && en;
  assign done       = active && (g_read || g_write) && !mem_wait;

  assign mem_read        = active & g_read;
  assign mem_write       = active & g_write;
  assign mem_atomic      = active & g_atomic;
  assign mem_addr        = forwarding ? g_addr : '0;
  assign mem_data_w      = forwarding ? g_data : '0;
  assign core_mem_data_r = mem_data_r;

  always_comb begin
    core_mem_wait = '0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      core_mem_wait[i] = req[i] & ~((grant == IDX_W'(i)) & active & ~mem_wait);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      last     <= IDX_W'(N_CORES - 1);
      lock_cnt <= '0;
    end else if (en) begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            grant <= pick;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!(g_read || g_write)) begin
            state <= IDLE;
          end else if (done) begin
            last <= grant;
            if (g_atomic && g_read) begin
              state    <= LOCK;
              lock_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        LOCK: begin
          if (done) begin
            last <= grant;
            if (g_atomic && g_write) begin
              state <= IDLE;
            end else begin
              lock_cnt <= '0;
            end
          end else if ((LOCK_TIMEOUT != 0) && (lock_cnt == CNT_LAST)) begin
            state <= IDLE;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter, N_CORES=2, LOCK_TIMEOUT=8, with a small RAM.
// Inputs change just after each falling edge; outputs are checked 1ns later.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [1:0]  core_mem_read   = '0;
  logic [1:0]  core_mem_write  = '0;
  logic [1:0]  core_mem_atomic = '0;
  logic [31:0] a0 = '0, a1 = '0, d0 = '0, d1 = '0;
  logic [63:0] core_mem_addr, core_mem_data_w;
  logic [31:0] core_mem_data_r;
  logic [1:0]  core_mem_wait;
  logic        mem_read, mem_write, mem_atomic;
  logic [31:0] mem_addr, mem_data_w, mem_data_r;
  logic        mem_wait = 1'b0;

  logic [31:0] ram [0:255];

  int vectors    = 0;
  int miscompares = 0;

  assign core_mem_addr   = {a1, a0};
  assign core_mem_data_w = {d1, d0};
  assign mem_data_r      = ram[mem_addr[7:0]];

  always #5 clk = ~clk;

  // RAM: reset seeds the words the scenarios read.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
      ram[100] <= 32'd1;
      ram[200] <= 32'd4;
    end else if (mem_write && !mem_wait) begin
      ram[mem_addr[7:0]] <= mem_data_w;
    end
  end

  mem_arbiter #(
    .N_CORES(2), .DATA_W(32), .ADDR_W(32), .LOCK_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .core_mem_read(core_mem_read), .core_mem_write(core_mem_write),
    .core_mem_atomic(core_mem_atomic),
    .core_mem_addr(core_mem_addr), .core_mem_data_w(core_mem_data_w),
    .core_mem_data_r(core_mem_data_r), .core_mem_wait(core_mem_wait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_atomic(mem_atomic),
    .mem_addr(mem_addr), .mem_data_w(mem_data_w),
    .mem_data_r(mem_data_r), .mem_wait(mem_wait)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    cyc(); rst = 1'b1; core_mem_read = '0; core_mem_write = '0; core_mem_atomic = '0;
    cyc(); rst = 1'b0;
  endtask

  initial begin
    // ---- reset: wait mirrors requests, strobes low
    cyc(); rst = 1'b1; core_mem_read = 2'b01; a0 = 32'd100; settle();
    chk("rst_wait", core_mem_wait, 2'b01);
    chk("rst_rd", mem_read, 1'b0);
    chk("rst_addr", mem_addr, 32'd0);

    // ---- single read: IDLE at t, served at t+1
    cyc(); rst = 1'b0; settle();
    chk("t_rd", mem_read, 1'b0);
    chk("t_wait", core_mem_wait, 2'b01);
    cyc(); settle();
    chk("t1_rd", mem_read, 1'b1);
    chk("t1_addr", mem_addr, 32'd100);
    chk("t1_wait", core_mem_wait, 2'b00);
    chk("t1_data", core_mem_data_r, 32'd1);
    cyc(); core_mem_read = '0; settle();
    chk("t2_rd", mem_read, 1'b0);

    // ---- round robin, both cores writing continuously
    do_reset();
    core_mem_write = 2'b11; a0 = 32'd10; d0 = 32'hA0; a1 = 32'd20; d1 = 32'hB1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("rr_idle_wait", core_mem_wait, 2'b11);
      chk("rr_idle_wr", mem_write, 1'b0);
      cyc(); settle();
      chk("rr_wr", mem_write, 1'b1);
      chk("rr_addr", mem_addr, (k % 2 == 0) ? 32'd10 : 32'd20);
      chk("rr_wait", core_mem_wait, (k % 2 == 0) ? 2'b10 : 2'b01);
      cyc();
    end
    settle();
    chk("rr_ram10", ram[10], 32'hA0);
    chk("rr_ram20", ram[20], 32'hB1);
    // RAM stall of 2 cycles on core 0's turn
    cyc(); mem_wait = 1'b1; settle();
    chk("mw_a_wait", core_mem_wait, 2'b11);
    chk("mw_a_addr", mem_addr, 32'd10);
    cyc(); settle();
    chk("mw_b_wait", core_mem_wait, 2'b11);
    cyc(); mem_wait = 1'b0; settle();
    chk("mw_c_wait", core_mem_wait, 2'b10);
    cyc(); core_mem_write = '0; settle();
    chk("mw_drop_wait", core_mem_wait, 2'b00);

    // ---- atomic lock: LOAD_A / other core write / STORE_A
    do_reset();
    core_mem_read = 2'b01; core_mem_atomic = 2'b01; a0 = 32'd200;
    core_mem_write = 2'b10; a1 = 32'd200; d1 = 32'd9; settle();
    chk("at_idle_wait", core_mem_wait, 2'b11);
    cyc(); settle();
    chk("at_ld_atomic", mem_atomic, 1'b1);
    chk("at_ld_data", core_mem_data_r, 32'd4);
    chk("at_ld_wait", core_mem_wait, 2'b10);
    cyc(); core_mem_read = 2'b00; core_mem_atomic = 2'b00; settle();
    chk("at_gap_wr", mem_write, 1'b0);
    chk("at_gap_wait", core_mem_wait, 2'b10);
    cyc(); core_mem_write = 2'b11; core_mem_atomic = 2'b01; d0 = 32'd5; settle();
    chk("at_st_data", mem_data_w, 32'd5);
    chk("at_st_atomic", mem_atomic, 1'b1);
    chk("at_st_wait", core_mem_wait, 2'b10);
    cyc(); core_mem_write = 2'b10; core_mem_atomic = 2'b00; settle();
    chk("at_post_wait", core_mem_wait, 2'b10);
    cyc(); settle();
    chk("at_c1_data", mem_data_w, 32'd9);
    chk("at_c1_wait", core_mem_wait, 2'b00);
    cyc(); core_mem_write = '0; settle();
    chk("at_ram200", ram[200], 32'd9);

    // ---- lock timeout: owner goes idle after LOAD_A
    do_reset();
    core_mem_read = 2'b01; core_mem_atomic = 2'b01; a0 = 32'd50;
    core_mem_write = 2'b10; a1 = 32'd60; d1 = 32'h77;
    cyc(); settle();
    chk("to_ld_rd", mem_read, 1'b1);
    cyc(); core_mem_read = '0; core_mem_atomic = '0;
    for (int k = 0; k < 9; k++) begin
      settle();
      chk("to_hold_wait", core_mem_wait, 2'b10);
      chk("to_hold_wr", mem_write, 1'b0);
      cyc();
    end
    settle();
    chk("to_grant_wr", mem_write, 1'b1);
    chk("to_grant_addr", mem_addr, 32'd60);
    chk("to_grant_wait", core_mem_wait, 2'b00);
    cyc(); core_mem_write = '0;

    // ---- enable dropped for 5 cycles during GRANT
    do_reset();
    core_mem_read = 2'b01; a0 = 32'd100;
    cyc(); en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("en_rd", mem_read, 1'b0);
      chk("en_wait", core_mem_wait, 2'b01);
      cyc();
    end
    en = 1'b1; settle();
    chk("en_back_rd", mem_read, 1'b1);
    chk("en_back_wait", core_mem_wait, 2'b00);
    chk("en_back_data", core_mem_data_r, 32'd1);

    // ---- reset while core 1 holds the lock
    cyc(); core_mem_read = 2'b10; core_mem_atomic = 2'b10; a1 = 32'd20;
    cyc(); settle();
    chk("rl_ld_addr", mem_addr, 32'd20);
    chk("rl_ld_atomic", mem_atomic, 1'b1);
    cyc(); rst = 1'b1; core_mem_read = 2'b01; core_mem_atomic = '0; settle();
    chk("rl_rst_wait", core_mem_wait, 2'b01);
    chk("rl_rst_rd", mem_read, 1'b0);
    chk("rl_rst_atomic", mem_atomic, 1'b0);
    cyc(); rst = 1'b0; core_mem_read = 2'b11; settle();
    chk("rl_idle_rd", mem_read, 1'b0);
    chk("rl_idle_wait", core_mem_wait, 2'b11);
    cyc(); settle();
    chk("rl_first_addr", mem_addr, 32'd100);
    chk("rl_first_wait", core_mem_wait, 2'b10);
    cyc(); core_mem_read = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shared-memory arbiter between the `mem_*` data ports of `N_CORES` CORE instances and the single shared data RAM (DUMMY_RAM in simulation). It sits directly downstream of each core's MEM stage: it grants one core at a time in round-robin order and forwards that core's request to the RAM. It also pins the grant to a core between its atomic load (LOAD_A) and atomic store (STORE_A), so read-modify-write sequences are indivisible across cores.

## Interface
- `N_CORES`, 2: number of core ports (2..8)
- `DATA_W`, 32: data width
- `ADDR_W`, 32: data address width (word address)
- `LOCK_TIMEOUT`, 64: cycles an atomic lock may be held without a completed access by its owner; 0 disables the timeout
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `en` in 1: global enable; when 0, state freezes
- `core_mem_read` in N_CORES: per-core read strobe
- `core_mem_write` in N_CORES: per-core write strobe
- `core_mem_atomic` in N_CORES: per-core atomic qualifier
- `core_mem_addr` in N_CORES*ADDR_W: packed addresses, core i at [i*ADDR_W +: ADDR_W]
- `core_mem_data_w` in N_CORES*DATA_W: packed write data
- `core_mem_data_r` out DATA_W: read data, broadcast to all cores, equal to `mem_data_r`
- `core_mem_wait` out N_CORES: per-core stall
- `mem_read`, `mem_write`, `mem_atomic` out 1 each: RAM strobes
- `mem_addr` out ADDR_W, `mem_data_w` out DATA_W: RAM request
- `mem_data_r` in DATA_W, `mem_wait` in 1: RAM response and stall

## Operation
- A core i requests when `core_mem_read[i] | core_mem_write[i]` is high. It holds the request stable until `core_mem_wait[i]` is low. A cycle where the core requests with wait low is that core's completion cycle.
- `core_mem_wait[i]` = request_i & ~(granted_i & forwarding & ~mem_wait & en). A non-requesting core always sees 0.
- Registers: state {IDLE, GRANT, LOCK}, `grant` (index), `last` (index of the last completed core), `lock_cnt`.
- IDLE:
  - RAM strobes are 0; addr and data_w are 0.
  - If any core requests, pick the first requester scanning `last+1, last+2, …` with wrap modulo N_CORES. Register it in `grant` and go to GRANT.
- GRANT:
  - The RAM ports are a combinational mux of core `grant`'s current signals, and `mem_atomic` passes through.
  - On completion, set `last <= grant`. Next state:
    - atomic read: LOCK, with `lock_cnt <= 0`
    - any other access: IDLE
  - If the granted core drops its request before completion (protocol violation), go to IDLE with no side effects.
- LOCK:
  - Only the owner (`grant`) is forwarded, and its request is forwarded in the same cycle with no arbitration cycle. Other requesters wait.
  - Owner completion of an atomic write: go to IDLE.
  - Owner completion of any other access: stay in LOCK and clear `lock_cnt`.
  - Every other cycle, `lock_cnt` increments. At `lock_cnt == LOCK_TIMEOUT-1` (when LOCK_TIMEOUT ≠ 0) with no owner completion, go to IDLE.
- `en = 0`:
  - No state, `grant`, `last` or `lock_cnt` updates.
  - RAM strobes are forced to 0.
  - Every requester sees wait = 1.
- Reset values: state IDLE, `grant` 0, `last` N_CORES-1 (so core 0 wins first), `lock_cnt` 0. While `rst` is high, RAM strobes are 0 and `core_mem_wait` equals the request vector. Reset mid-transaction abandons the transaction: the RAM sees the strobes drop, and any lock is released.

## Timing
- Request in IDLE at cycle t: grant registered at edge t+1. The RAM sees the request during cycle t+1, and with `mem_wait` = 0 the core completes in t+1. Minimum latency is 1 arbitration cycle plus the RAM wait cycles.
- In LOCK, owner accesses have 0 arbitration cycles: the request and completion are in the same cycle when `mem_wait` = 0.
- Back-to-back requests from one core with others idle: one access every 2 cycles (IDLE/GRANT alternation).
- `core_mem_data_r` is valid only in the completion cycle of a read.
- All forwarding paths are combinational: core inputs to RAM outputs, and `mem_wait` to `core_mem_wait`. There are no registered data paths.

## Test plan
- Single request, N_CORES=2: core 0 reads addr 100 (RAM[100]=1) at cycle t, with zero-wait RAM. Expect `mem_read` high with `mem_addr`=100 in t+1, `core_mem_wait[0]` low in t+1, `core_mem_data_r`=1.
- Contention and round-robin: both cores continuously write (core 0 to addr 10, core 1 to addr 20). Expect grants in the order 0,1,0,1; no core waits more than 2 grants; `mem_wait` held high 2 cycles extends each completion by exactly 2 cycles.
- Atomic lock: core 0 issues LOAD_A on 200 (value 4), core 1 requests write 200←9, core 0 issues STORE_A 200←5. Expect core 1 stalled until core 0's STORE_A completes; final RAM[200]=9; core 0 read 4.
- Lock timeout with LOCK_TIMEOUT=8: core 0 issues LOAD_A and then goes idle; core 1 requests. Expect core 1 granted after the 8 lock cycles plus 1 arbitration cycle.
- Enable and reset: drop `en` for 5 cycles during GRANT (expect strobes 0, waits high, grant preserved, completion after `en` returns). Assert `rst` during LOCK (expect IDLE next cycle, strobes 0, and core 0 winning the first arbitration after reset).
